// File: rtl/vec_mem_pkg.sv
// Shared types and sizing helpers for the vector memory engine.
// Holds the FSM state encoding and the lane-slice geometry used by top and bench alike.
package vec_mem_pkg;

    localparam int DEF_WORD_W = 32;
    localparam int DEF_LANES  = 16;
    localparam int DEF_DEPTH  = 512;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RESP  = 2'd3
    } vec_state_e;

    // Lanes are packed MSB-first: lane 0 sits in the top word of the vector.
    function automatic int lane_lsb(input int lane, input int lanes, input int word_w);
        return (lanes - 1 - lane) * word_w;
    endfunction

    function automatic int lane_cnt_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/vec_mem_sram.sv
// Single-port WORD_W x DEPTH storage with synchronous read and write enable.
// One access per cycle; a write does not update the read port.
module vec_mem_sram
    import vec_mem_pkg::*;
#(
    parameter int   WORD_W = DEF_WORD_W,
    parameter int   DEPTH  = DEF_DEPTH,
    localparam int  ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto a RAM macro; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/vec_mem_engine.sv
// Strided/masked vector load-store engine over a single-port word SRAM, one lane per cycle.
// Define VEC_MEM_STRIDE_EN to honour req_stride; otherwise accesses are unit-stride.
module vec_mem_engine
    import vec_mem_pkg::*;
#(
    parameter int   WORD_W = DEF_WORD_W,
    parameter int   LANES  = DEF_LANES,
    parameter int   DEPTH  = DEF_DEPTH,
    localparam int  ADDR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [ADDR_W-1:0]       req_stride,
    input  logic [LANES-1:0]        req_mask,
    input  logic [LANES*WORD_W-1:0] req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [LANES*WORD_W-1:0] rsp_rdata,
    output logic                    busy
);

    localparam int                VEC_W     = LANES * WORD_W;
    localparam int                LANE_W    = lane_cnt_w(LANES);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    vec_state_e        state_q, state_d;
    logic [LANE_W-1:0] lane_q;
    logic [ADDR_W-1:0] lane_addr_q, stride_q, stride_in;
    logic              we_q;
    logic [LANES-1:0]  mask_q;
    logic [VEC_W-1:0]  wdata_q, rdata_q;
    logic              accept;

    // Return tags follow the read data: stage 1 lines up with the SRAM port, stage 2 with dout_q.
    logic              ret1_valid_q, ret1_cap_q, ret2_valid_q, ret2_cap_q;
    logic [LANE_W-1:0] ret1_lane_q, ret2_lane_q;
    logic [WORD_W-1:0] dout_q;

    logic              sram_en;
    logic [WORD_W-1:0] sram_wdata, sram_rdata;

`ifdef VEC_MEM_STRIDE_EN
    assign stride_in = req_stride;
`else
    logic unused_stride;
    assign unused_stride = ^req_stride;
    assign stride_in     = ADDR_W'(1);
`endif

    function automatic logic [ADDR_W-1:0] wrap_add(input logic [ADDR_W-1:0] a,
                                                   input logic [ADDR_W-1:0] b);
        return ADDR_W'((int'(a) + int'(b)) % DEPTH);
    endfunction

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req_valid)                                 state_d = ST_BUSY;
            ST_BUSY:  if (lane_q == LAST_LANE)                       state_d = ST_DRAIN;
            ST_DRAIN: if (ret2_valid_q && ret2_lane_q == LAST_LANE)  state_d = ST_RESP;
            ST_RESP:  if (rsp_ready)                                 state_d = ST_IDLE;
            default:                                                 state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b1;
        rsp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_RESP: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign accept     = req_valid && req_ready;
    assign sram_en    = (state_q == ST_BUSY) && mask_q[lane_q];
    assign sram_wdata = wdata_q[lane_lsb(int'(lane_q), LANES, WORD_W) +: WORD_W];
    assign rsp_rdata  = rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q       <= '0;
            lane_addr_q  <= '0;
            stride_q     <= '0;
            we_q         <= 1'b0;
            mask_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            ret1_valid_q <= 1'b0;
            ret1_cap_q   <= 1'b0;
            ret1_lane_q  <= '0;
            ret2_valid_q <= 1'b0;
            ret2_cap_q   <= 1'b0;
            ret2_lane_q  <= '0;
            dout_q       <= '0;
        end else begin
            ret1_valid_q <= (state_q == ST_BUSY);
            ret1_cap_q   <= sram_en && !we_q;
            ret1_lane_q  <= lane_q;
            ret2_valid_q <= ret1_valid_q;
            ret2_cap_q   <= ret1_cap_q;
            ret2_lane_q  <= ret1_lane_q;
            // Re-register read data so the wide lane-steering mux starts from a flop.
            dout_q       <= sram_rdata;

            if (accept) begin
                lane_q      <= '0;
                lane_addr_q <= req_addr;
                stride_q    <= stride_in;
                we_q        <= req_we;
                mask_q      <= req_mask;
                wdata_q     <= req_wdata;
                rdata_q     <= '0;
            end else begin
                if (state_q == ST_BUSY) begin
                    lane_q      <= (lane_q == LAST_LANE) ? '0 : lane_q + 1'b1;
                    lane_addr_q <= wrap_add(lane_addr_q, stride_q);
                end
                if (ret2_valid_q && ret2_cap_q) begin
                    rdata_q[lane_lsb(int'(ret2_lane_q), LANES, WORD_W) +: WORD_W] <= dout_q;
                end
            end
        end
    end

    vec_mem_sram #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) u_sram (
        .clk   (clk),
        .en    (sram_en),
        .we    (we_q),
        .addr  (lane_addr_q),
        .wdata (sram_wdata),
        .rdata (sram_rdata)
    );

endmodule

// File: tb/tb_vec_mem_engine.sv
// Scoreboard bench for vec_mem_engine: driver queues expected responses, monitor checks them.
// Stride expectations follow VEC_MEM_STRIDE_EN.
`timescale 1ns/1ps
module tb_vec_mem_engine;

    localparam int W   = 32;
    localparam int L   = 16;
    localparam int D   = 512;
    localparam int AW  = 9;
    localparam int LAT = L + 2;

    typedef logic [L*W-1:0] vec_t;
    typedef struct {
        vec_t data;
        int   acc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr, req_stride;
    logic [L-1:0]  req_mask;
    vec_t          req_wdata, rsp_rdata;
    logic          rsp_valid, rsp_ready, busy;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic resp_open = 1'b0;
    vec_t held;
    vec_t exp_v, base_v;

    vec_mem_engine #(.WORD_W(W), .LANES(L), .DEPTH(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_stride (req_stride),
        .req_mask   (req_mask),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input vec_t act, input vec_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t set_lane(input vec_t v, input int i, input logic [W-1:0] x);
        vec_t r;
        r = v;
        r[(L-1-i)*W +: W] = x;
        return r;
    endfunction

    function automatic vec_t ramp(input int base);
        vec_t v;
        v = '0;
        for (int i = 0; i < L; i++) v = set_lane(v, i, W'(base + i));
        return v;
    endfunction

    function automatic vec_t fill(input logic [W-1:0] x);
        vec_t v;
        v = '0;
        for (int i = 0; i < L; i++) v = set_lane(v, i, x);
        return v;
    endfunction

    function automatic vec_t keep_lanes(input vec_t v, input logic [L-1:0] m);
        vec_t r;
        r = v;
        for (int i = 0; i < L; i++) if (!m[i]) r = set_lane(r, i, '0);
        return r;
    endfunction

    // Monitor: first cycle of each response pops the scoreboard, later cycles check it holds.
    always @(negedge clk) begin
        if (!rst_n) begin
            resp_open = 1'b0;
        end else if (rsp_valid && !resp_open) begin
            resp_open = 1'b1;
            held      = rsp_rdata;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, mon_e.data);
                check("rsp_latency", vec_t'(cyc - mon_e.acc), vec_t'(LAT));
            end
        end else if (rsp_valid) begin
            check("rsp_rdata_stable", rsp_rdata, held);
            check("req_ready_in_resp", vec_t'(req_ready), '0);
        end else begin
            resp_open = 1'b0;
        end
    end

    task automatic issue(input logic we, input int addr, input int stride, input logic [L-1:0] mask,
                         input vec_t wdata, input vec_t exp, input int hold, input bit wait_rsp);
        int n;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            tests++;
            fails++;
            $display("FAIL req_ready_timeout: got req_ready=0 expected 1");
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = AW'(addr);
        req_stride = AW'(stride);
        req_mask   = mask;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        if (wait_rsp) exp_q.push_back('{data: exp, acc: cyc});
        check("busy_ready_after_accept", vec_t'({busy, req_ready}), vec_t'(2'b10));
        // Scramble the request bus: the engine must work from its latched copy.
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_addr   = AW'($urandom);
        req_stride = AW'($urandom);
        req_mask   = L'($urandom);
        req_wdata  = {L{32'($urandom)}};
        if (wait_rsp) begin
            n = 0;
            @(negedge clk);
            while (!rsp_valid && n < 4 * LAT) begin
                @(negedge clk);
                n++;
            end
            if (!rsp_valid) begin
                tests++;
                fails++;
                $display("FAIL rsp_timeout: got rsp_valid=0 expected 1");
            end
            repeat (hold) @(negedge clk);
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_stride = '0;
        req_mask   = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_req_ready", vec_t'(req_ready), vec_t'(1));
        check("reset_rsp_valid", vec_t'(rsp_valid), '0);
        check("reset_busy", vec_t'(busy), '0);
        check("reset_rsp_rdata", rsp_rdata, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Unit-stride store then load of the same 16 words.
        issue(1'b1, 0, 1, 16'hFFFF, ramp(1), '0, 0, 1'b1);
        issue(1'b0, 0, 1, 16'hFFFF, '0, ramp(1), 0, 1'b1);

        // Store across the top of storage: words 510,511,0..13 get A0..AF.
        issue(1'b1, 510, 1, 16'hFFFF, ramp(32'hA0), '0, 0, 1'b1);
        exp_v = ramp(32'hA2);
        exp_v = set_lane(exp_v, 14, 32'd15);
        exp_v = set_lane(exp_v, 15, 32'd16);
        issue(1'b0, 0, 1, 16'hFFFF, '0, exp_v, 0, 1'b1);

`ifdef VEC_MEM_STRIDE_EN
        // Stride 3: lane i lands in word 3i, words between keep their old data.
        issue(1'b1, 0, 3, 16'hFFFF, ramp(0), '0, 0, 1'b1);
        for (int k = 0; k < L; k++) begin
            if (k % 3 == 0)  exp_v = set_lane(exp_v, k, W'(k / 3));
            else if (k < 14) exp_v = set_lane(exp_v, k, W'(32'hA2 + k));
            else             exp_v = set_lane(exp_v, k, 32'd15);
        end
        issue(1'b0, 0, 1, 16'hFFFF, '0, exp_v, 0, 1'b1);
`else
        // Stride is ignored: a stride-3 store still fills 16 consecutive words.
        issue(1'b1, 0, 3, 16'hFFFF, ramp(0), '0, 0, 1'b1);
        issue(1'b0, 0, 3, 16'hFFFF, '0, ramp(0), 0, 1'b1);
`endif

        // Partial mask over a prefilled block, then masked and fully masked traffic.
        issue(1'b1, 64, 1, 16'hFFFF, fill(32'hFFFF_FFFF), '0, 0, 1'b1);
        issue(1'b1, 64, 1, 16'h00FF, ramp(32'h10), '0, 0, 1'b1);
        base_v = fill(32'hFFFF_FFFF);
        for (int i = 0; i < 8; i++) base_v = set_lane(base_v, i, W'(32'h10 + i));
        issue(1'b0, 64, 1, 16'hFFFF, '0, base_v, 0, 1'b1);
        issue(1'b0, 64, 1, 16'h00FF, '0, keep_lanes(base_v, 16'h00FF), 0, 1'b1);
        issue(1'b1, 64, 1, 16'h0000, ramp(32'h99), '0, 0, 1'b1);
        issue(1'b0, 64, 1, 16'hFFFF, '0, base_v, 0, 1'b1);

        // Stride 0 aliasing with a held-off response.
        issue(1'b1, 200, 0, 16'hFFFF, ramp(0), '0, 5, 1'b1);
`ifdef VEC_MEM_STRIDE_EN
        issue(1'b0, 200, 0, 16'hFFFF, '0, fill(32'd15), 5, 1'b1);
`else
        issue(1'b0, 200, 0, 16'hFFFF, '0, ramp(0), 5, 1'b1);
`endif

        // Reset while lane 6 is in flight: lanes 0..5 stay written, the rest keep old data.
        issue(1'b1, 300, 1, 16'hFFFF, fill(32'hEEEE_EEEE), '0, 0, 1'b1);
        issue(1'b1, 300, 1, 16'hFFFF, ramp(32'h50), '0, 0, 1'b0);
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_req_ready", vec_t'(req_ready), vec_t'(1));
        check("abort_rsp_valid", vec_t'(rsp_valid), '0);
        check("abort_busy", vec_t'(busy), '0);
        check("abort_rsp_rdata", rsp_rdata, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_v = fill(32'hEEEE_EEEE);
        for (int i = 0; i < 6; i++) exp_v = set_lane(exp_v, i, W'(32'h50 + i));
        issue(1'b0, 300, 1, 16'hFFFF, '0, exp_v, 0, 1'b1);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", vec_t'(exp_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vec_mem_engine.md
VEC_MEM_ENGINE -- requirements
Module: vec_mem_engine

Interface
REQ-001 The block SHALL have parameters: WORD_W, default 32, element width in bits.
REQ-002 The block SHALL have parameters: LANES, default 16, elements per vector.
REQ-003 The block SHALL have parameters: DEPTH, default 512, words in storage; ADDR_W = clog2(DEPTH) is derived, not overridable.
REQ-004 The block SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-005 The block SHALL have ports: rst_n  in  1  reset; it is asynchronous and active-low.
REQ-006 The block SHALL have ports: req_valid  in  1  request offered.
REQ-007 The block SHALL have ports: req_ready  out  1  engine can accept (high only in IDLE).
REQ-008 The block SHALL have ports: req_we  in  1  1 = vector store, 0 = vector load.
REQ-009 The block SHALL have ports: req_addr  in  ADDR_W  base word address.
REQ-010 The block SHALL have ports: req_stride  in  ADDR_W  word stride between lanes.
REQ-011 The block SHALL have ports: req_mask  in  LANES  lane enable, bit i = lane i.
REQ-012 The block SHALL have ports: req_wdata  in  LANES*WORD_W  store data.
REQ-013 The block SHALL have ports: rsp_valid  out  1  response available.
REQ-014 The block SHALL have ports: rsp_ready  in  1  response consumed.
REQ-015 The block SHALL have ports: rsp_rdata  out  LANES*WORD_W  load data.
REQ-016 The block SHALL have ports: busy  out  1  high in any state other than IDLE.

Function
REQ-017 Lane packing SHALL be MSB-first: lane i occupies bits [(LANES-i)*WORD_W-1 -: WORD_W].
REQ-018 Lane i address SHALL be (req_addr + i*req_stride) mod DEPTH, so addresses wrap past DEPTH-1 to 0.
REQ-019 The FSM SHALL have states IDLE, BUSY, DRAIN, RESP; handshake accepts only on req_valid && req_ready.
REQ-020 On accept, the engine SHALL latch all req_* fields and move IDLE->BUSY; req_* changes afterwards SHALL have no effect.
REQ-021 In BUSY the engine SHALL perform one single-word storage access per cycle, lane 0 first, lane LANES-1 last, then go to DRAIN.
REQ-022 Storage reads SHALL be synchronous (1-cycle); DRAIN captures the last lane's read data, then goes to RESP.
REQ-023 rsp_valid SHALL rise exactly LANES+2 cycles after the accept edge for loads and stores alike.
REQ-024 rsp_valid SHALL hold, with rsp_rdata stable, until rsp_ready is high; on that edge go RESP->IDLE.
REQ-025 A new request SHALL be accepted no earlier than the cycle after that edge (no back-to-back overlap).
REQ-026 Masked-off lanes SHALL not write storage; their load result SHALL be 0.
REQ-027 For a store, rsp_rdata SHALL be all-zero; rsp_valid acts as write completion.
REQ-028 When lanes alias (e.g. stride 0), stores SHALL apply in lane order so the highest enabled lane wins; loads broadcast.
REQ-029 A fully masked request (mask 0) SHALL still take the full LANES+2 latency and touch no storage.

Reset
REQ-030 While rst_n is low: state IDLE, req_ready=1, rsp_valid=0, busy=0, rsp_rdata=0, lane counter 0.
REQ-031 Reset asserted mid-operation SHALL abort the vector; any lanes already written stay written.
REQ-032 Storage contents SHALL not be reset.

Configuration
REQ-033 With VEC_MEM_STRIDE_EN defined, req_stride SHALL be honoured per REQ-018.
REQ-034 Without VEC_MEM_STRIDE_EN, req_stride SHALL be ignored and stride fixed at 1 (unit-stride); latency is unchanged.

Structure
REQ-035 State encoding enum and lane-slice width constants SHALL live in shared package vec_mem_pkg.
REQ-036 Storage SHALL be a separate sub-module vec_mem_sram: single-port, WORD_W x DEPTH, synchronous read, write-enable, no reset.

Verification
REQ-037 Reset then store base 0, stride 1, mask FFFF, lane i = i+1; load same -> rsp_rdata lane i = i+1, rsp_valid at accept+18.
REQ-038 Store base 510, stride 1, lane i = 0xA0+i; load base 0 -> lanes 0..13 = 0xA2..0xAF (wrap check).
REQ-039 Stride 3 (VEC_MEM_STRIDE_EN on): store lane i = i at 3i; load stride 1 base 0 -> word 3 = 1, word 4 untouched; macro off -> stride ignored.
REQ-040 Mask 0x00FF store over prefilled 0xFFFFFFFF -> lanes 8..15 keep 0xFFFFFFFF; masked load of those lanes returns 0.
REQ-041 Stride 0 store lane i = i -> word base = 15; hold rsp_ready low 5 cycles -> rsp_valid/data stable, req_ready stays 0.
REQ-042 rst_n pulsed low during BUSY lane 6 -> outputs at reset values immediately; lanes 0..5 written; next request completes normally.
